// File: rtl/fp_accumulator.sv
// fp_accumulator: sums a frame of signed fixed-point samples and emits one converted result per frame.
// Optional macro FP_ACCUM_SAT_EN: saturate on output overflow (default build wraps).
module fp_accumulator #(
   parameter int WI    = 8,
   parameter int WF    = 32,
   parameter int WIO   = 8,
   parameter int WFO   = 32,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WI+WF-1:0]     A,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CNT_W-1:0]     len,
   output logic [WIO+WFO-1:0]   out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overflow
);
   localparam int IW = WI + WF;
   localparam int AW = WI + CNT_W + WF;
   localparam int SW = WI + CNT_W + WFO;
   localparam int OW = WIO + WFO;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

   state_t                r_state, w_state_nxt;
   logic signed [AW-1:0]  r_acc;
   logic [CNT_W-1:0]      r_cnt, r_len_q;
   logic signed [AW-1:0]  w_a_ext, w_sum;
   logic [CNT_W-1:0]      w_len_eff;
   logic [SW-1:0]         w_conv;
   logic [OW-1:0]         w_out;
   logic                  w_ovf, w_last, w_accept;

   assign w_a_ext   = {{CNT_W{A[IW-1]}}, A};
   assign w_sum     = (r_state == S_IDLE) ? w_a_ext : r_acc + w_a_ext;
   assign w_len_eff = (len == '0) ? CNT_W'(1) : len;
   assign w_accept  = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = ~reset;
            w_last   = (w_len_eff == CNT_W'(1));
            if (in_valid) w_state_nxt = w_last ? S_HOLD : S_ACC;
         end
         S_ACC: begin
            in_ready = ~reset;
            w_last   = (({1'b0, r_cnt} + (CNT_W+1)'(1)) == {1'b0, r_len_q});
            if (in_valid && w_last) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Result is captured from the final sum so it is ready the cycle HOLD is entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_len_q  <= '0;
         out      <= '0;
         overflow <= 1'b0;
      end else if (w_accept) begin
         r_acc <= w_sum;
         if (r_state == S_IDLE) begin
            r_len_q <= w_len_eff;
            r_cnt   <= CNT_W'(1);
         end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
         end
         if (w_last) begin
            out      <= w_out;
            overflow <= w_ovf;
         end
      end
   end

   generate
      if (WFO > WF) begin : g_frac_ext
         assign w_conv = {w_sum, {(WFO-WF){1'b0}}};
      end else if (WFO == WF) begin : g_frac_eq
         assign w_conv = w_sum;
      end else begin : g_frac_trunc
         // Dropping LSBs of a two's-complement value rounds toward minus infinity.
         assign w_conv = w_sum[AW-1:WF-WFO];
      end

      if (SW > OW) begin : g_narrow
         logic [SW-OW:0] w_top;
         assign w_top = w_conv[SW-1:OW-1];
         assign w_ovf = !((&w_top) || !(|w_top));
`ifdef FP_ACCUM_SAT_EN
         assign w_out = !w_ovf ? w_conv[OW-1:0] :
                        (w_conv[SW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
`else
         assign w_out = w_conv[OW-1:0];
`endif
      end else if (SW == OW) begin : g_same
         assign w_ovf = 1'b0;
         assign w_out = w_conv;
      end else begin : g_widen
         assign w_ovf = 1'b0;
         assign w_out = {{(OW-SW){w_conv[SW-1]}}, w_conv};
      end
   endgenerate

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential fixed-point accumulator that sits directly downstream of the FPadder datapath. It sums a frame of `len` signed two's-complement samples delivered over a valid/ready stream. It emits one result per frame, converted to the output format, with an overflow flag. Internal precision is wide enough that the sum never overflows inside the block; range loss happens only at the output conversion.

## Interface
- `WI`, default 8: input integer bits, including sign.
- `WF`, default 32: input fractional bits.
- `WIO`, default 8: output integer bits, including sign.
- `WFO`, default 32: output fractional bits.
- `CNT_W`, default 8: width of the frame-length field.
- `clk` input 1: the only clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state.
- `A` input `WI+WF`: input sample, signed fixed point (WI.WF).
- `in_valid` input 1: `A` is valid.
- `in_ready` output 1: the block accepts `A` this cycle.
- `len` input `CNT_W`: samples per frame. Sampled with the first sample of each frame.
- `out` output `WIO+WFO`: frame sum, signed fixed point (WIO.WFO).
- `out_valid` output 1: `out` and `overflow` are valid.
- `out_ready` input 1: downstream consumes `out`.
- `overflow` output 1: the frame sum did not fit the output format.

## Operation
- Internal accumulator `acc`:
  - Signed, `WI+CNT_W` integer bits and `WF` fractional bits.
  - Cannot overflow for any frame of at most 2^CNT_W samples.
- Sign-extend each sample before adding.
- States:
  - **IDLE**: `in_ready`=1. On `in_valid`:
    - `acc`←A.
    - Latch `len` into `len_q`; `len`=0 is treated as 1.
    - `cnt`←1.
    - If `len_q`==1, go to HOLD; otherwise go to ACC.
  - **ACC**: `in_ready`=1. On `in_valid`:
    - `acc`←`acc`+A.
    - `cnt`←`cnt`+1.
    - When `cnt`+1==`len_q`, go to HOLD.
  - **HOLD**: `in_ready`=0, `out_valid`=1.
    - `out` and `overflow` are registered and held stable.
    - On `out_ready`, go to IDLE.
- Output conversion, registered on entry to HOLD:
  - Fractional part: if WFO≥WF, append zero LSBs. If WFO<WF, drop LSBs (truncate toward −∞).
  - Integer part: if the result lies in [−2^(WIO−1), 2^(WIO−1)−2^−WFO], pass it through and set `overflow`=0.
  - Otherwise set `overflow`=1 and apply the range policy in Configuration.
- `len` is ignored except on the first accepted sample of a frame.
- Changes to `len` in mid-frame have no effect.

## Timing
- Reset values: `in_ready`=0 while `reset` is asserted, then 1 (IDLE). `out_valid`=0, `out`=0, `overflow`=0, `acc`=0, `cnt`=0.
- Throughput is one sample per cycle in IDLE/ACC.
- Latency: `out_valid` rises on the cycle after the last sample is accepted.
- Returning HOLD→IDLE costs one bubble cycle. `in_ready` is 0 during the HOLD cycle where `out_ready` is sampled high.
- `out` and `overflow` must not change while `out_valid`=1 and `out_ready`=0.
- `in_ready` does not depend combinationally on `out_ready`.
- Reset asserted mid-frame or in HOLD aborts the frame. No partial result is emitted.

## Configuration
- `FP_ACCUM_SAT_EN` defined: on overflow, `out` saturates to the maximum (0 followed by all 1s) or minimum (1 followed by all 0s) according to the sign of `acc`.
- `FP_ACCUM_SAT_EN` undefined: on overflow, `out` wraps, keeping the low `WIO` integer bits. This matches the FPadder overflow behaviour.
- `overflow` is asserted identically in both builds.

## Test plan
All scenarios use default parameters.
- **Basic sum:** `len`=4, four samples of 1.5 (0x01_80000000) → `out`=0x06_00000000, `overflow`=0, `out_valid` one cycle after the fourth accept.
- **Negative sum:** `len`=2, samples 0xFF_80000000 (−0.5) twice → `out`=0xFF_00000000 (−1.0), `overflow`=0.
- **Overflow:** `len`=3, samples 0x64_00000000 (100.0) → `overflow`=1.
  - `out`=0x7F_FFFFFFFF with `FP_ACCUM_SAT_EN` defined.
  - `out`=0x2C_00000000 (44.0) without it.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in HOLD → `out` stable, `in_ready`=0, extra `in_valid` ignored. Then `out_ready`=1 → IDLE next cycle.
- **len=0 and mid-frame len change:** `len`=0 with one sample 0x02_00000000 → `out`=0x02_00000000. Separately, start a frame with `len`=3 and change `len` to 1 after the first accept → three samples are still summed.
- **Reset mid-frame:** assert `reset` after 2 of 4 samples → `out_valid`=0 and `out`=0 immediately. A following `len`=1 frame of 0x00_40000000 → `out`=0x00_40000000.
